// File: rtl/hexagonal_fragment_sink_if.sv
// Fragment-stream and framebuffer-write signal bundle for hexagonal_fragment_sink.
// slave is the sink's view; master is the rasterizer/framebuffer side.
interface hexagonal_fragment_sink_if #(
    parameter int ADDR_W = 10
);
    logic                in_valid;
    logic signed [15:0]  q_in;
    logic signed [15:0]  r_in;
    logic [7:0]          depth_in;
    logic                src_busy;
    logic                clear;
    logic                fb_valid;
    logic                fb_ready;
    logic [ADDR_W-1:0]   fb_addr;
    logic [7:0]          fb_depth;
    logic                frag_done;
    logic                overflow;
    logic [15:0]         dropped_count;
    logic                busy;

    modport slave (
        input  in_valid, q_in, r_in, depth_in, src_busy, clear, fb_ready,
        output fb_valid, fb_addr, fb_depth, frag_done, overflow, dropped_count, busy
    );

    modport master (
        output in_valid, q_in, r_in, depth_in, src_busy, clear, fb_ready,
        input  fb_valid, fb_addr, fb_depth, frag_done, overflow, dropped_count, busy
    );
endinterface

// File: rtl/hexagonal_fragment_sink.sv
// Buffers the hex fragment stream, converts axial->odd-q offset, culls, depth-tests
// against an internal depth buffer and issues surviving writes on a valid/ready port.
module hexagonal_fragment_sink #(
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 10
) (
    input  logic clk,
    input  logic reset_n,
    hexagonal_fragment_sink_if.slave sif
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int NCELL   = GRID_W * GRID_H;
    localparam int DB_SIZE = 1 << ADDR_W;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NCELL - 1);
    localparam logic [ADDR_W-1:0] GW_A     = ADDR_W'(GRID_W);
    localparam logic signed [16:0] GW_S    = 17'(GRID_W);
    localparam logic signed [16:0] GH_S    = 17'(GRID_H);

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] r;
        logic [7:0]         depth;
    } frag_t;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              fb_valid_q, fb_valid_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_depth_q, fb_depth_d;
    logic              frag_done_q, frag_done_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       dropped_q, dropped_d;
    logic              done_pending_q, done_pending_d;
    logic              src_busy_q;

    frag_t       fifo_mem [FIFO_DEPTH];
    logic [7:0]  depth_buf [DB_SIZE];

    frag_t              head;
    logic signed [16:0] col, row;
    logic [ADDR_W-1:0]  addr;
    logic [7:0]         buf_rd;
    logic run, empty, full, hs, pop, push, drop, cull, pass, done_fire, fall;

    assign run   = (state_q == ST_RUN);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign hs    = fb_valid_q & sif.fb_ready;
    assign pop   = run & ~empty & (~fb_valid_q | sif.fb_ready);
    assign push  = run & sif.in_valid & (~full | pop) & ~sif.clear;
    assign drop  = run & sif.in_valid & ~push & ~sif.clear;
    assign fall  = src_busy_q & ~sif.src_busy;

    // (q - (q & 1)) >>> 1 is just q >>> 1, sign-extended to 17 bits
    assign head = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign col  = {head.q[15], head.q};
    assign row  = $signed({head.r[15], head.r}) + $signed({{2{head.q[15]}}, head.q[15:1]});
    assign cull = col[16] | row[16] | (col >= GW_S) | (row >= GH_S);
    assign addr = row[ADDR_W-1:0] * GW_A + col[ADDR_W-1:0];
    assign buf_rd = depth_buf[addr];
    assign pass = pop & ~cull & (head.depth < buf_rd) & ~sif.clear;

    // Emptiness already implies no pop this cycle
    assign done_fire = done_pending_q & empty & (~fb_valid_q | sif.fb_ready) & ~sif.clear;
    assign frag_done_d = done_fire;

    always_comb begin
        state_d        = state_q;
        clear_idx_d    = clear_idx_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        fb_valid_d     = fb_valid_q;
        fb_addr_d      = fb_addr_q;
        fb_depth_d     = fb_depth_q;
        overflow_d     = overflow_q;
        dropped_d      = dropped_q;
        done_pending_d = done_pending_q;
        if (sif.clear) begin
            state_d        = ST_CLEAR;
            clear_idx_d    = '0;
            rd_ptr_d       = wr_ptr_q;
            fb_valid_d     = 1'b0;
            done_pending_d = 1'b0;
            overflow_d     = 1'b0;
            dropped_d      = '0;
        end else begin
            if (state_q == ST_CLEAR) begin
                clear_idx_d = clear_idx_q + ADDR_W'(1);
                if (clear_idx_q == LAST_IDX) state_d = ST_RUN;
            end
            if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            if (pass) begin
                fb_valid_d = 1'b1;
                fb_addr_d  = addr;
                fb_depth_d = head.depth;
            end else if (hs) begin
                fb_valid_d = 1'b0;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
            end
            if (done_fire)  done_pending_d = 1'b0;
            else if (fall)  done_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_CLEAR;
            clear_idx_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fb_valid_q     <= 1'b0;
            fb_addr_q      <= '0;
            fb_depth_q     <= '0;
            frag_done_q    <= 1'b0;
            overflow_q     <= 1'b0;
            dropped_q      <= '0;
            done_pending_q <= 1'b0;
            src_busy_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            clear_idx_q    <= clear_idx_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fb_valid_q     <= fb_valid_d;
            fb_addr_q      <= fb_addr_d;
            fb_depth_q     <= fb_depth_d;
            frag_done_q    <= frag_done_d;
            overflow_q     <= overflow_d;
            dropped_q      <= dropped_d;
            done_pending_q <= done_pending_d;
            src_busy_q     <= sif.src_busy;
        end
    end

    // Storage arrays carry no reset; the depth buffer is initialised by the CLEAR sweep
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {sif.q_in, sif.r_in, sif.depth_in};
        if (state_q == ST_CLEAR && !sif.clear) depth_buf[clear_idx_q] <= 8'hFF;
        else if (pass)                         depth_buf[addr] <= head.depth;
    end

    assign sif.fb_valid      = fb_valid_q;
    assign sif.fb_addr       = fb_addr_q;
    assign sif.fb_depth      = fb_depth_q;
    assign sif.frag_done     = frag_done_q;
    assign sif.overflow      = overflow_q;
    assign sif.dropped_count = dropped_q;
    assign sif.busy          = (state_q == ST_CLEAR) | ~empty | fb_valid_q | done_pending_q;
endmodule

// File: tb/tb_hexagonal_fragment_sink.sv
// Self-checking bench for hexagonal_fragment_sink with a plain-arithmetic hex/depth model.
module tb_hexagonal_fragment_sink;
    localparam int GW = 32;
    localparam int GH = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hexagonal_fragment_sink_if #(.ADDR_W(AW)) sif ();
    hexagonal_fragment_sink #(.GRID_W(GW), .GRID_H(GH), .FIFO_DEPTH(16), .ADDR_W(AW))
        dut (.clk(clk), .reset_n(reset_n), .sif(sif));

    int checks = 0;
    int failures = 0;
    int cyc = 0, done_n = 0, done_cyc = 0, fbv_n = 0;
    logic [17:0] wr_q [$];
    int          wr_cyc [$];
    logic [17:0] exp_q [$];
    int          ref_db [GW*GH];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sif.fb_valid && sif.fb_ready) begin
            wr_q.push_back({sif.fb_addr, sif.fb_depth});
            wr_cyc.push_back(cyc);
        end
        if (sif.frag_done) begin
            done_n   <= done_n + 1;
            done_cyc <= cyc;
        end
        if (sif.fb_valid) fbv_n <= fbv_n + 1;
    end

    function automatic void model_reset();
        foreach (ref_db[i]) ref_db[i] = 255;
        exp_q.delete();
    endfunction

    // Axial -> odd-q offset, bounds cull, strict-less depth test
    function automatic void model_frag(int q, int r, int d);
        int col, row, a;
        col = q;
        row = r + (q - (q & 1)) / 2;
        if (col < 0 || col >= GW || row < 0 || row >= GH) return;
        a = row * GW + col;
        if (d < ref_db[a]) begin
            ref_db[a] = d;
            exp_q.push_back({AW'(a), 8'(d)});
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int q, int r, int d);
        sif.in_valid = 1'b1;
        sif.q_in     = 16'(q);
        sif.r_in     = 16'(r);
        sif.depth_in = 8'(d);
        tick();
        sif.in_valid = 1'b0;
        model_frag(q, r, d);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (sif.busy && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_clear();
        sif.clear = 1'b1;
        tick();
        sif.clear = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        sif.in_valid = 0; sif.q_in = 0; sif.r_in = 0; sif.depth_in = 0;
        sif.src_busy = 0; sif.clear = 0; sif.fb_ready = 1;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++; if (sif.fb_valid !== 1'b0) begin failures++; $display("FAIL rst_fb_valid got=%0b exp=0", sif.fb_valid); end
        checks++; if (sif.fb_addr !== '0) begin failures++; $display("FAIL rst_fb_addr got=%0d exp=0", sif.fb_addr); end
        checks++; if (sif.frag_done !== 1'b0 || sif.overflow !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b exp=00", sif.frag_done, sif.overflow); end
        checks++; if (sif.dropped_count !== 16'd0) begin failures++; $display("FAIL rst_dropped got=%0d exp=0", sif.dropped_count); end
        checks++; if (sif.busy !== 1'b1) begin failures++; $display("FAIL rst_busy got=%0b exp=1", sif.busy); end
        reset_n = 1'b1;
        n = 0;
        while (sif.busy && n < 3000) begin
            sif.in_valid = (n < 100);
            sif.q_in = 16'($urandom_range(0, 31));
            sif.r_in = 16'($urandom_range(0, 15));
            sif.depth_in = 8'($urandom_range(0, 255));
            tick();
            n++;
        end
        sif.in_valid = 1'b0;
        checks++; if (n != 1024) begin failures++; $display("FAIL clear_cycles got=%0d exp=1024", n); end
        checks++; if (sif.dropped_count !== 16'd0 || sif.overflow !== 1'b0) begin failures++; $display("FAIL clear_drops got=%0d exp=0", sif.dropped_count); end
        repeat (4) tick();
        checks++; if (fbv_n != 0 || wr_q.size() != 0) begin failures++; $display("FAIL clear_fb_valid got=%0d exp=0", fbv_n); end
        model_reset();
    endtask

    task automatic test_single();
        wr_q.delete();
        sif.fb_ready = 1'b1;
        send(3, 2, 0);
        checks++; if (sif.fb_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%0b exp=0", sif.fb_valid); end
        tick();
        checks++; if (sif.fb_valid !== 1'b1 || sif.fb_addr !== AW'(99) || sif.fb_depth !== 8'd0)
            begin failures++; $display("FAIL single_write got=%0b/%0d/%0d exp=1/99/0", sif.fb_valid, sif.fb_addr, sif.fb_depth); end
        repeat (5) tick();
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", wr_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_depth();
        int n;
        wr_q.delete(); exp_q.delete();
        send(5, 4, 0);
        send(5, 4, 0);
        send(5, 4, 5);
        send(3, 2, 5);
        wait_idle(n);
        checks++; if (wr_q.size() != 1) begin failures++; $display("FAIL depth_count got=%0d exp=1", wr_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL depth_stream[%0d] got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_cull();
        int n, fbv0;
        wr_q.delete(); exp_q.delete();
        fbv0 = fbv_n;
        send(-1, 0, 0);
        send(0, 40, 0);
        send(32, 0, 0);
        send(-4, 1, 0);
        wait_idle(n);
        checks++; if (fbv_n != fbv0 || sif.overflow !== 1'b0) begin failures++; $display("FAIL cull_fb_valid got=%0d exp=%0d", fbv_n, fbv0); end
        send(0, 0, 0);
        wait_idle(n);
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL cull_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL cull_stream[%0d] got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        int n;
        do_clear();
        wait_idle(n);
        checks++; if (n != 1024) begin failures++; $display("FAIL ovf_clear got=%0d exp=1024", n); end
        model_reset(); wr_q.delete(); wr_cyc.delete();
        sif.fb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sif.in_valid = 1'b1; sif.q_in = 16'(i); sif.r_in = 16'd0; sif.depth_in = 8'd0;
            tick();
            if (i < 17) model_frag(i, 0, 0);
        end
        sif.in_valid = 1'b0;
        checks++; if (sif.overflow !== 1'b1 || sif.dropped_count !== 16'd3)
            begin failures++; $display("FAIL ovf_drops got=%0b/%0d exp=1/3", sif.overflow, sif.dropped_count); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (sif.fb_valid !== 1'b1 || sif.fb_addr !== AW'(0) || sif.fb_depth !== 8'd0)
                begin failures++; $display("FAIL ovf_hold got=%0b/%0d exp=1/0", sif.fb_valid, sif.fb_addr); end
            tick();
        end
        sif.fb_ready = 1'b1;
        wait_idle(n);
        checks++; if (wr_q.size() != 17) begin failures++; $display("FAIL ovf_count got=%0d exp=17", wr_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_stream[%0d] got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
        end
        if (wr_cyc.size() == 17) begin
            checks++; if (wr_cyc[16] - wr_cyc[0] != 16) begin failures++; $display("FAIL ovf_gaps got=%0d exp=16", wr_cyc[16] - wr_cyc[0]); end
        end
    endtask

    task automatic test_primitive();
        int n, k, d0;
        wr_q.delete(); exp_q.delete(); wr_cyc.delete();
        d0 = done_n; k = 0;
        sif.src_busy = 1'b1;
        for (int dq = -2; dq <= 2; dq++)
            for (int dr = -2; dr <= 2; dr++)
                if (dq + dr >= -2 && dq + dr <= 2) begin
                    sif.fb_ready = (k % 2 == 0);
                    k++;
                    send(10 + dq, 10 + dr, $urandom_range(0, 254));
                end
        sif.src_busy = 1'b0;
        n = 0;
        while (sif.busy && n < 400) begin
            sif.fb_ready = (k % 2 == 0);
            k++;
            tick();
            n++;
        end
        sif.fb_ready = 1'b1;
        repeat (3) tick();
        checks++; if (n >= 400) begin failures++; $display("FAIL prim_timeout got=%0d exp=<400", n); end
        checks++; if (wr_q.size() != 19 || exp_q.size() != 19) begin failures++; $display("FAIL prim_count got=%0d exp=19", wr_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL prim_stream[%0d] got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (done_n - d0 != 1) begin failures++; $display("FAIL prim_done_pulses got=%0d exp=1", done_n - d0); end
        if (wr_cyc.size() > 0) begin
            checks++; if (done_cyc <= wr_cyc[wr_cyc.size()-1])
                begin failures++; $display("FAIL prim_done_order got=%0d exp=>%0d", done_cyc, wr_cyc[wr_cyc.size()-1]); end
        end
    endtask

    task automatic test_clear_mid();
        int n, k, d0, wr_at_clear;
        wr_q.delete();
        d0 = done_n; k = 0;
        for (int i = 0; i < 8; i++) begin
            sif.fb_ready = (k % 2 == 0);
            k++;
            send(20 + (i % 3), 5 + i / 3, 7);
        end
        sif.fb_ready = 1'b1;
        do_clear();
        checks++; if (sif.fb_valid !== 1'b0 || sif.busy !== 1'b1)
            begin failures++; $display("FAIL midclr_state got=%0b/%0b exp=0/1", sif.fb_valid, sif.busy); end
        wr_at_clear = wr_q.size();
        wait_idle(n);
        checks++; if (n != 1024) begin failures++; $display("FAIL midclr_cycles got=%0d exp=1024", n); end
        repeat (4) tick();
        checks++; if (wr_q.size() != wr_at_clear) begin failures++; $display("FAIL midclr_flush got=%0d exp=%0d", wr_q.size(), wr_at_clear); end
        checks++; if (done_n != d0) begin failures++; $display("FAIL midclr_done got=%0d exp=%0d", done_n - d0, 0); end
        checks++; if (sif.overflow !== 1'b0 || sif.dropped_count !== 16'd0)
            begin failures++; $display("FAIL midclr_ovf got=%0b/%0d exp=0/0", sif.overflow, sif.dropped_count); end
        model_reset();
    endtask

    task automatic test_random();
        int n;
        wr_q.delete(); exp_q.delete();
        for (int i = 0; i < 150; i++) begin
            sif.fb_ready = ($urandom_range(0, 3) != 0);
            send($urandom_range(0, 40) - 4, $urandom_range(0, 56) - 20, $urandom_range(0, 255));
            repeat (3) begin
                sif.fb_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        sif.fb_ready = 1'b1;
        wait_idle(n);
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < wr_q.size()) begin
            checks++; if (wr_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_stream[%0d] got=%0h exp=%0h", i, wr_q[i], exp_q[i]); end
        end
        checks++; if (sif.overflow !== 1'b0) begin failures++; $display("FAIL rand_overflow got=%0b exp=0", sif.overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_depth();
        test_cull();
        test_overflow();
        test_primitive();
        test_clear_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hexagonal_fragment_sink.md
Name: hexagonal_fragment_sink

Overview:
Consumes the per-cycle hex fragment stream (q, r, depth, valid) produced by the hex fill rasterizer. The stream has no backpressure, so fragments land in an internal FIFO first. Each fragment is converted from axial to odd-q offset coordinates, culled against the grid bounds, and depth-tested against an internal depth buffer. Surviving fragments are issued as framebuffer writes on a valid/ready port. Sits between the rasterizer and the framebuffer writer.

Parameters:
GRID_W, 32, grid width in hexes (columns)
GRID_H, 32, grid height in hexes (rows)
FIFO_DEPTH, 16, input FIFO entries (power of 2)
ADDR_W, 10, framebuffer address width; must satisfy 2**ADDR_W >= GRID_W*GRID_H

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  fragment present this cycle; no ready, always sampled
q_in  in  16  signed axial q
r_in  in  16  signed axial r
depth_in  in  8  fragment depth; smaller is nearer
src_busy  in  1  rasterizer busy; a 1->0 transition marks end of primitive
clear  in  1  one-cycle pulse: start a new frame
fb_valid  out  1  framebuffer write valid
fb_ready  in  1  framebuffer accepts write
fb_addr  out  ADDR_W  row*GRID_W + col
fb_depth  out  8  depth written
frag_done  out  1  one-cycle pulse: primitive fully drained
overflow  out  1  sticky: at least one fragment dropped
dropped_count  out  16  dropped fragments, saturates at 16'hFFFF
busy  out  1  combinational: state==CLEAR, FIFO non-empty, fb_valid, or done pending

Behaviour:
- Reset (async assert, sync release): state=CLEAR, clear_idx=0, FIFO empty, fb_valid=0, fb_addr=0, fb_depth=0, frag_done=0, overflow=0, dropped_count=0, done_pending=0, src_busy_q=0.
- State CLEAR: write 8'hFF to depth_buf[clear_idx], one entry per cycle, for GRID_W*GRID_H cycles, then go to RUN. in_valid is ignored and not counted. fb_valid is held 0.
- clear pulse in any state: enter CLEAR with clear_idx=0, flush FIFO, set fb_valid=0, done_pending=0, overflow=0, dropped_count=0. clear has priority over every other event in the same cycle.
- FIFO push: in_valid in RUN with (not full or pop this cycle) -> push {q,r,depth}. Otherwise the fragment is dropped: overflow<=1 and dropped_count increments (saturating).
- Pop (RUN): occurs when FIFO is non-empty and (fb_valid==0 or fb_ready==1). A fragment pushed at edge N can be popped at edge N+1. Throughput is 1 fragment/cycle.
- Popped fragment processing, all combinational in the pop cycle:
  - col = q
  - row = r + ((q - (q & 1)) >>> 1), 17-bit signed arithmetic
  - Cull if col<0, col>=GRID_W, row<0, or row>=GRID_H.
  - Otherwise addr = row*GRID_W + col.
  - Pass if depth < depth_buf[addr]. On pass: depth_buf[addr]<=depth, fb_addr<=addr, fb_depth<=depth, fb_valid<=1.
- On cull or fail: no depth buffer update. fb_valid<=0 if fb_ready was consumed, else unchanged.
- fb handshake: transfer when fb_valid and fb_ready. fb_addr and fb_depth are stable while fb_valid=1 and fb_ready=0.
- src_busy_q registers src_busy. A 1->0 edge sets done_pending.
- frag_done fires for one cycle when done_pending=1, FIFO is empty, no pop is occurring, and fb_valid=0 (or the final handshake happens this cycle); done_pending clears in the same cycle. A new falling edge while done_pending=1 has no additional effect.

Test Plan:
1. Release reset, fb_ready=1, idle inputs -> busy=1 for 1024 cycles then 0; fb_valid never asserted; in_valid during CLEAR does not increment dropped_count.
2. After CLEAR, fragment q=3, r=2, depth=0 at cycle N -> fb_valid=1 in cycle N+2 with fb_addr=99 (row 3, col 3), fb_depth=0; single write.
3. Same fragment sent twice -> exactly one fb write (second fails 0<0); depth=5 at addr 99 afterwards is also rejected.
4. Fragments (q=-1,r=0), (q=0,r=40), (q=32,r=0) -> no fb_valid, overflow=0, and depth buffer unchanged: a later (0,0,depth=0) still writes addr 0.
5. fb_ready=0, 20 consecutive fragments q=0..19, r=0, depth=0 -> 17 accepted (1 output register + 16 FIFO), 3 dropped; overflow=1, dropped_count=3. Then fb_ready=1 -> 17 writes in order q=0..16 with no gaps.
6. Radius-2 hex around (10,10): 19 fragments with src_busy high, then low; fb_ready toggling 1010 -> 19 writes, one frag_done pulse after the last handshake. A clear pulse mid-stream instead -> fb_valid drops next cycle, FIFO is flushed, 1024-cycle CLEAR runs, and no frag_done fires.
